// File: rtl/aes_pkg.sv
// Shared AES block/word widths, typedefs and word-slot helpers.
// Word 0 of a block is the most significant 32 bits.
package aes_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int AES_WORD_W    = 32;
  localparam int WORDS_PER_BLK = 4;

  typedef logic [AES_BLK_W-1:0]               aes_blk_t;
  typedef logic [AES_WORD_W-1:0]              aes_word_t;
  typedef logic [$clog2(WORDS_PER_BLK)-1:0]   word_idx_t;

  function automatic aes_word_t blk_word(input aes_blk_t b, input word_idx_t idx);
    case (idx)
      2'd0:    return b[127:96];
      2'd1:    return b[95:64];
      2'd2:    return b[63:32];
      default: return b[31:0];
    endcase
  endfunction

  function automatic aes_blk_t blk_put(input aes_blk_t b, input word_idx_t idx,
                                       input aes_word_t w);
    aes_blk_t r;
    r = b;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous 128-bit result buffer with occupancy count; head is shown
// combinationally. Writes are never offered when full.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH = 12
) (
  input  logic                               clk,
  input  logic                               clr,
  input  logic                               i_wr_en,
  input  logic [AES_BLK_W-1:0]               i_wr_data,
  input  logic                               i_rd_en,
  output logic [AES_BLK_W-1:0]               o_head,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count,
  output logic                               o_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  aes_blk_t         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_rd;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign w_rd    = i_rd_en && (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd)    r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({i_wr_en, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/aes_word_feeder.sv
// Packs 32-bit words into 128-bit cipher blocks, tracks in-flight blocks and
// unpacks results. Optional blk_count output with AES_FEEDER_STATS_EN.
module aes_word_feeder
  import aes_pkg::*;
#(
  parameter int LATENCY    = 10,
  parameter int FIFO_DEPTH = 12
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [AES_WORD_W-1:0] in_word,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [AES_BLK_W-1:0]  blk_out,
  output logic                  blk_issue,
  input  logic [AES_BLK_W-1:0]  res_in,
  output logic [AES_WORD_W-1:0] out_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
`ifdef AES_FEEDER_STATS_EN
  ,
  output logic [31:0]           blk_count
`endif
);

  localparam int IF_W  = $clog2(LATENCY+1);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int SUM_W = 8;

  word_idx_t          r_wcnt;
  logic               r_pending;
  aes_blk_t           r_blk;
  logic [LATENCY-1:0] r_vsr;
  word_idx_t          r_k;

  logic [IF_W-1:0]    w_inflight;
  logic [CNT_W-1:0]   w_fifo_cnt;
  logic               w_fifo_empty;
  aes_blk_t           w_head;
  logic               w_issue;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_pop;
  logic               w_capture;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) w_inflight = w_inflight + IF_W'(r_vsr[i]);
  end

  // Issue only when every in-flight block is guaranteed a FIFO slot on return.
  assign w_issue    = r_pending &&
                      ((SUM_W'(w_inflight) + SUM_W'(w_fifo_cnt)) < SUM_W'(FIFO_DEPTH));
  assign w_in_xfer  = in_valid && !r_pending;
  assign w_out_xfer = !w_fifo_empty && out_ready;
  assign w_pop      = w_out_xfer && (r_k == word_idx_t'(WORDS_PER_BLK-1));
  assign w_capture  = r_vsr[LATENCY-1];

  always_ff @(posedge clk) begin
    if (clr) begin
      r_wcnt    <= '0;
      r_pending <= 1'b0;
      r_blk     <= '0;
    end else if (w_in_xfer) begin
      r_blk  <= blk_put(r_blk, r_wcnt, in_word);
      r_wcnt <= r_wcnt + 1'b1;
      if (r_wcnt == word_idx_t'(WORDS_PER_BLK-1)) r_pending <= 1'b1;
    end else if (w_issue) begin
      r_pending <= 1'b0;
    end
  end

  // Valid shadow of the cipher pipeline; clearing it drops stale results.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_vsr <= '0;
    end else begin
      r_vsr[0] <= w_issue;
      for (int i = 1; i < LATENCY; i++) r_vsr[i] <= r_vsr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr)             r_k <= '0;
    else if (w_out_xfer) r_k <= r_k + 1'b1;
  end

  aes_blk_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .i_wr_en   (w_capture),
    .i_wr_data (res_in),
    .i_rd_en   (w_pop),
    .o_head    (w_head),
    .o_count   (w_fifo_cnt),
    .o_empty   (w_fifo_empty)
  );

`ifdef AES_FEEDER_STATS_EN
  logic [31:0] r_blk_count;

  always_ff @(posedge clk) begin
    if (clr)        r_blk_count <= '0;
    else if (w_pop) r_blk_count <= r_blk_count + 1'b1;
  end

  assign blk_count = r_blk_count;
`endif

  assign in_ready  = !r_pending;
  assign blk_out   = r_blk;
  assign blk_issue = w_issue;
  assign out_valid = !w_fifo_empty;
  assign out_word  = blk_word(w_head, r_k);
  assign busy      = (r_wcnt != '0) || r_pending || (w_inflight != '0) || !w_fifo_empty;

endmodule
